// File: rtl/linked_list_pkg.sv
// ============================================================================
// Module      : linked_list_pkg
// Description : Shared op encodings, NULL-address helper and traverser states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package linked_list_pkg;

  localparam logic [1:0] OP_READ       = 2'd0;
  localparam logic [1:0] OP_DELETE     = 2'd1;
  localparam logic [1:0] OP_PUSH_BACK  = 2'd2;
  localparam logic [1:0] OP_PUSH_FRONT = 2'd3;

  // All-ones address of the given width marks the end of the list.
  function automatic int unsigned null_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  typedef enum logic [2:0] {
    TRV_IDLE  = 3'd0,
    TRV_ISSUE = 3'd1,
    TRV_WAIT  = 3'd2,
    TRV_EMIT  = 3'd3,
    TRV_FIN   = 3'd4,
    TRV_ERR   = 3'd5
  } trav_state_e;

endpackage

`default_nettype wire

// File: rtl/linked_list_traverser.sv
// ============================================================================
// Module      : linked_list_traverser
// Description : Walks a linked_list head-to-tail via Read ops and streams each
//               node payload out. Optional LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
//               aborts on out-of-range next pointers and on cyclic lists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module linked_list_traverser
  import linked_list_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] count,
  output logic [1:0]            ll_op,
  output logic                  ll_op_start,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [DATA_WIDTH-1:0] ll_data,
  input  logic [ADDR_WIDTH-1:0] ll_next_addr,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic                  ll_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] c_NULL = ADDR_WIDTH'(null_addr(ADDR_WIDTH));

  trav_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_nxt;
  logic [ADDR_WIDTH-1:0] w_count_inc;
  logic                  w_bad_next;
  logic                  w_loop;

  assign ll_op       = OP_READ;
  assign w_count_inc = count + ADDR_WIDTH'(1);

`ifdef LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] c_MAX_ADDR = ADDR_WIDTH'(MAX_NODE);
  assign w_bad_next = (ll_next_addr != c_NULL) && (ll_next_addr >= c_MAX_ADDR);
  assign w_loop     = (w_count_inc == c_MAX_ADDR);
`else
  assign w_bad_next = 1'b0;
  assign w_loop     = 1'b0;
`endif

  // ll_addr doubles as the current-node pointer; it only changes on entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TRV_IDLE;
      r_nxt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      count       <= '0;
      ll_op_start <= 1'b0;
      ll_addr     <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
    end else begin
      done        <= 1'b0;
      fault       <= 1'b0;
      ll_op_start <= 1'b0;
      case (r_state)
        TRV_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= '0;
            if (ll_empty) begin
              done    <= 1'b1;
              r_state <= TRV_FIN;
            end else begin
              ll_addr     <= ll_head;
              ll_op_start <= 1'b1;
              r_state     <= TRV_ISSUE;
            end
          end
        end
        TRV_ISSUE: r_state <= TRV_WAIT;
        TRV_WAIT: begin
          if (ll_op_done) begin
            if (ll_fault || w_bad_next) begin
              fault   <= 1'b1;
              r_state <= TRV_ERR;
            end else begin
              m_data  <= ll_data;
              r_nxt   <= ll_next_addr;
              m_last  <= (ll_next_addr == c_NULL);
              m_valid <= 1'b1;
              r_state <= TRV_EMIT;
            end
          end
        end
        TRV_EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            count   <= w_count_inc;
            if (r_nxt == c_NULL) begin
              done    <= 1'b1;
              r_state <= TRV_FIN;
            end else if (w_loop) begin
              fault   <= 1'b1;
              r_state <= TRV_ERR;
            end else begin
              ll_addr     <= r_nxt;
              ll_op_start <= 1'b1;
              r_state     <= TRV_ISSUE;
            end
          end
        end
        TRV_FIN, TRV_ERR: begin
          busy    <= 1'b0;
          r_state <= TRV_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= TRV_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linked_list_traverser.sv
// ============================================================================
// Module      : tb_linked_list_traverser
// Description : Scoreboard bench: list responder model, random lists, stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_linked_list_traverser;

  localparam int DW = 8;
`ifdef LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
  localparam int MAXN = 4;
`else
  localparam int MAXN = 8;
`endif
  localparam int AW    = $clog2(MAXN + 1);
  localparam int NULLA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fault;
  logic [AW-1:0] count;
  logic [1:0]    ll_op;
  logic          ll_op_start;
  logic [AW-1:0] ll_addr;
  logic          ll_op_done = 1'b0;
  logic          ll_fault = 1'b0;
  logic [DW-1:0] ll_data = '0;
  logic [AW-1:0] ll_next_addr = '0;
  logic [AW-1:0] ll_head = '0;
  logic          ll_empty = 1'b1;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;

  linked_list_traverser #(.DATA_WIDTH(DW), .MAX_NODE(MAXN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fault(fault), .count(count), .ll_op(ll_op), .ll_op_start(ll_op_start),
    .ll_addr(ll_addr), .ll_op_done(ll_op_done), .ll_fault(ll_fault),
    .ll_data(ll_data), .ll_next_addr(ll_next_addr), .ll_head(ll_head),
    .ll_empty(ll_empty), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int last; } beat_t;
  typedef struct { int is_fault; int cnt; } end_t;

  beat_t beat_q[$];
  end_t  end_q[$];
  int    addr_q[$];

  int mem_data [0:15];
  int mem_next [0:15];
  int head_i, fault_idx = -1, lat_fix = 0, ready_mode = 0, noise_en = 0;
  int start_req = 0, rd_idx = 0, ends_seen = 0;
  int resp_cnt = 0, resp_addr = 0, resp_idx = 0, cyc = 0;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the list array the way the spec describes it.
  task automatic build_expect();
    int a, k, nx;
    end_t e;
    beat_t b;
    if (ll_empty) begin
      e.is_fault = 0; e.cnt = 0; end_q.push_back(e);
      return;
    end
    a = head_i;
    k = 0;
    while (k < 64) begin
      addr_q.push_back(a);
      if (k == fault_idx) begin
        e.is_fault = 1; e.cnt = k; end_q.push_back(e);
        return;
      end
      nx = mem_next[a];
`ifdef LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
      if (nx != NULLA && nx >= MAXN) begin
        e.is_fault = 1; e.cnt = k; end_q.push_back(e);
        return;
      end
`endif
      b.d = mem_data[a]; b.last = (nx == NULLA) ? 1 : 0;
      beat_q.push_back(b);
      k++;
      if (nx == NULLA) begin
        e.is_fault = 0; e.cnt = k % (1 << AW); end_q.push_back(e);
        return;
      end
`ifdef LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
      if (k == MAXN) begin
        e.is_fault = 1; e.cnt = k; end_q.push_back(e);
        return;
      end
`endif
      a = nx;
    end
  endtask

  // Single driver of all DUT inputs except reset/list head: list responder,
  // stream back-pressure and start pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        resp_cnt   = 0;
        ll_op_done = 1'b0;
        start      = 1'b0;
      end else begin
        ll_op_done = 1'b0;
        ll_fault   = 1'($urandom_range(0, 1));
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            ll_op_done   = 1'b1;
            ll_fault     = (resp_idx == fault_idx);
            ll_data      = DW'(mem_data[resp_addr]);
            ll_next_addr = AW'(mem_next[resp_addr]);
          end
        end
        if (ll_op_start) begin
          chk("one_outstanding_op", resp_cnt, 0);
          chk("op_code_read", ll_op, 0);
          if (addr_q.size() == 0) chk("unexpected_op_start", 1, 0);
          else chk("read_addr", ll_addr, addr_q.pop_front());
          resp_addr = int'(ll_addr);
          resp_idx  = rd_idx;
          rd_idx++;
          resp_cnt  = (lat_fix > 0) ? lat_fix : $urandom_range(1, 3);
        end
        case (ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (cyc % 3 == 0);
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (start_req != 0) begin
          start     = 1'b1;
          start_req = 0;
          rd_idx    = 0;
        end else begin
          start = busy && (noise_en != 0) && ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Monitor: pops expected beats / end events whenever the DUT presents one.
  initial begin
    int    prev_stall = 0;
    int    prev_d = 0, prev_l = 0;
    beat_t b;
    end_t  e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall != 0) begin
          chk("stall_valid_held", m_valid, 1);
          chk("stall_data_held", m_data, prev_d);
          chk("stall_last_held", m_last, prev_l);
        end
        if (m_valid && m_ready) begin
          if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            b = beat_q.pop_front();
            chk("beat_data", m_data, b.d);
            chk("beat_last", m_last, b.last);
          end
        end
        prev_stall = (m_valid && !m_ready) ? 1 : 0;
        prev_d = int'(m_data);
        prev_l = int'(m_last);
        if (done || fault) begin
          chk("busy_during_end", busy, 1);
          if (end_q.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            e = end_q.pop_front();
            chk("end_is_fault", fault, e.is_fault);
            chk("end_is_done", done, 1 - e.is_fault);
            chk("end_count", count, e.cnt);
          end
          ends_seen++;
        end
      end
    end
  end

  task automatic run_trav();
    int e0, got;
    e0 = ends_seen;
    got = 0;
    build_expect();
    start_req = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (ends_seen > e0) begin
        got = 1;
        break;
      end
    end
    if (got == 0) chk("traversal_timeout", 0, 1);
    @(negedge clk);
    chk("busy_low_after_end", busy, 0);
    chk("beats_outstanding", beat_q.size(), 0);
    chk("ends_outstanding", end_q.size(), 0);
    chk("reads_outstanding", addr_q.size(), 0);
    beat_q.delete(); end_q.delete(); addr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 16; i++) begin
      mem_data[i] = $urandom_range(0, 255);
      mem_next[i] = $urandom_range(0, NULLA);
    end
  endtask

  task automatic set_list3();
    fill_garbage();
    head_i = 1; ll_head = AW'(1); ll_empty = 1'b0;
    mem_data[1] = 'h11; mem_next[1] = 2;
    mem_data[2] = 'h22; mem_next[2] = 3;
    mem_data[3] = 'h33; mem_next[3] = NULLA;
  endtask

  task automatic set_random_list();
    int perm[MAXN];
    int n, j, t;
    fill_garbage();
    for (int i = 0; i < MAXN; i++) perm[i] = i;
    for (int i = MAXN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    n = $urandom_range(0, MAXN);
    ll_empty = (n == 0);
    head_i   = perm[0];
    ll_head  = AW'(head_i);
    for (int i = 0; i < n; i++) mem_next[perm[i]] = (i == n - 1) ? NULLA : perm[i + 1];
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);     chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);   chk("rst_op_start", ll_op_start, 0);
    chk("rst_count", count, 0);     chk("rst_m_data", m_data, 0);
    chk("rst_ll_op", ll_op, 0);     chk("rst_ll_addr", ll_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_garbage();
    ll_empty = 1'b1;
    run_trav();

    set_list3(); lat_fix = 1; ready_mode = 0;
    run_trav();
    ready_mode = 1;
    run_trav();
    ready_mode = 0; fault_idx = 1;
    run_trav();
    fault_idx = -1;

`ifdef LINKED_LIST_TRAVERSER_BOUND_CHECK_EN
    fill_garbage();
    head_i = 0; ll_head = '0; ll_empty = 1'b0;
    mem_next[0] = 1; mem_next[1] = 0;
    run_trav();
    fill_garbage();
    head_i = 2; ll_head = AW'(2); mem_next[2] = 6;
    run_trav();
`endif

    lat_fix = 0; noise_en = 1;
    for (int i = 0; i < 40; i++) begin
      set_random_list();
      ready_mode = $urandom_range(0, 2);
      fault_idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXN - 1) : -1;
      run_trav();
    end
    noise_en = 0; fault_idx = -1;

    // Reset while the first read is outstanding.
    set_list3(); lat_fix = 3; ready_mode = 0;
    build_expect();
    start_req = 1;
    w = 0;
    while (rd_idx < 1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (rd_idx < 1) chk("reset_test_no_read", 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);       chk("midrst_m_valid", m_valid, 0);
    chk("midrst_op_start", ll_op_start, 0);
    chk("midrst_ll_addr", ll_addr, 0); chk("midrst_count", count, 0);
    chk("midrst_m_data", m_data, 0);   chk("midrst_done", done, 0);
    beat_q.delete(); end_q.delete(); addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lat_fix = 0; ready_mode = 2;
    run_trav();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
